// File: rtl/reaction_test_controller.sv
// Reaction speed tester sequencing FSM.
// Flow: start press -> random wait -> GO LED -> measure time to respond press in ms (BCD).
// Early presses give FOUL. No press before 9999 ms gives TIMEOUT.
// Optional feature macro: BEST_TIME_EN (best valid time register on best_bcd).
module reaction_test_controller #(
    parameter int          TICK_DIV     = 100000,
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          RAND_BITS    = 11,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        respond,
    output logic        led_go,
    output logic [15:0] result_bcd,
    output logic [2:0]  state,
    output logic        foul,
    output logic        timeout,
    output logic [15:0] best_bcd
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_GO      = 3'd2,
        S_DONE    = 3'd3,
        S_FOUL    = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(MIN_DELAY_MS + 2**RAND_BITS) + 1;

    state_t          cur, nxt;
    logic            start_q, respond_q;
    logic            start_e, respond_e;
    logic [15:0]     lfsr;
    logic [PW-1:0]   prescaler;
    logic            tick;
    logic [DW-1:0]   delay_cnt;
    logic            enter_timed;
    logic            at_max;

    assign start_e   = start & ~start_q;
    assign respond_e = respond & ~respond_q;
    assign tick      = (prescaler == PW'(TICK_DIV - 1));
    assign at_max    = (result_bcd == 16'h9999);
    assign state     = cur;

    // Prescaler restarts whenever a timed phase begins so its first ms is full length.
    assign enter_timed = (nxt != cur) && ((nxt == S_WAIT) || (nxt == S_GO));

    // Decimal increment with per-digit carry (9 -> 0 carries into the next digit).
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Previous-cycle button levels. These keep sampling during reset, so a button
    // still held when reset releases is treated as an old level, not a fresh press.
    always_ff @(posedge clk) begin
        start_q   <= start;
        respond_q <= respond;
    end

    // Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), shifts every cycle.
    always_ff @(posedge clk) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) cur <= S_IDLE;
        else       cur <= nxt;
    end

    // Next-state logic. Respond beats delay expiry and timeout in the same cycle.
    always_comb begin
        nxt = cur;
        unique case (cur)
            S_IDLE, S_DONE, S_FOUL, S_TIMEOUT: begin
                if (start_e) nxt = S_WAIT;
            end
            S_WAIT: begin
                if (respond_e)                         nxt = S_FOUL;
                else if (tick && (delay_cnt == DW'(1))) nxt = S_GO;
            end
            S_GO: begin
                if (respond_e)          nxt = S_DONE;
                else if (tick && at_max) nxt = S_TIMEOUT;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // 1 ms tick generator.
    always_ff @(posedge clk) begin
        if (reset)                    prescaler <= '0;
        else if (enter_timed || tick) prescaler <= '0;
        else                          prescaler <= prescaler + PW'(1);
    end

    // Delay countdown and elapsed-time BCD counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            delay_cnt  <= '0;
            result_bcd <= 16'h0000;
        end else begin
            unique case (cur)
                S_IDLE, S_DONE, S_FOUL, S_TIMEOUT: begin
                    if (start_e) begin
                        delay_cnt  <= DW'(MIN_DELAY_MS) + DW'(lfsr[RAND_BITS-1:0]);
                        result_bcd <= 16'h0000;
                    end
                end
                S_WAIT: begin
                    if (respond_e)  result_bcd <= 16'h0000;
                    else if (tick) delay_cnt  <= delay_cnt - DW'(1);
                end
                S_GO: begin
                    // A press in the tick cycle freezes the count without the increment.
                    if (!respond_e && tick && !at_max) result_bcd <= bcd_inc(result_bcd);
                end
                default: ;
            endcase
        end
    end

    // Status outputs registered alongside the state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_go  <= 1'b0;
            foul    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            led_go  <= (nxt == S_GO);
            foul    <= (nxt == S_FOUL);
            timeout <= (nxt == S_TIMEOUT);
        end
    end

`ifdef BEST_TIME_EN
    logic        done_q;
    logic [15:0] best_q;

    // Flags the first DONE cycle so the frozen result is compared one cycle later.
    always_ff @(posedge clk) begin
        if (reset) done_q <= 1'b0;
        else       done_q <= (cur == S_GO) && (nxt == S_DONE);
    end

    // Best valid time. For valid BCD, a plain unsigned compare equals a digit-wise
    // compare starting at the most significant digit.
    always_ff @(posedge clk) begin
        if (reset)                              best_q <= 16'h9999;
        else if (done_q && (result_bcd < best_q)) best_q <= result_bcd;
    end

    assign best_bcd = best_q;
`else
    assign best_bcd = 16'h9999;
`endif

endmodule

// File: tb/tb_reaction_test_controller.sv
// Randomized self-checking bench for reaction_test_controller.
// Expected outcomes come from trial-level arithmetic: wait = 4*delay cycles,
// measured ms = (cycles from GO to respond edge) / TICK_DIV, timeout after 10000 ticks.
module tb_reaction_test_controller;

    localparam int TD  = 4;
    localparam int MIN = 2;
    localparam int RB  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        respond = 1'b0;
    logic        led_go;
    logic [15:0] result_bcd;
    logic [2:0]  state;
    logic        foul;
    logic        timeout;
    logic [15:0] best_bcd;

    int          total = 0;
    int          bad = 0;
    logic [15:0] m_lfsr;
    logic [15:0] exp_best = 16'h9999;

    reaction_test_controller #(
        .TICK_DIV(TD), .MIN_DELAY_MS(MIN), .RAND_BITS(RB), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .respond(respond),
        .led_go(led_go), .result_bcd(result_bcd), .state(state),
        .foul(foul), .timeout(timeout), .best_bcd(best_bcd)
    );

    always #5 clk = ~clk;

    // Reference pseudo-random sequence: 16-bit Fibonacci, taps 16,14,13,11.
    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Starts a trial and returns the programmed delay in ms.
    task automatic begin_trial(input bit want_lfsr1, output int d);
        int n;
        start = 1'b0;
        respond = 1'b0;
        cyc(2);
        n = 0;
        while (want_lfsr1 && m_lfsr[1:0] != 2'd1 && n < 100) begin
            cyc(1);
            n++;
        end
        d = MIN + int'(m_lfsr[RB-1:0]);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("wait_entry", state, 3'd1);
        chk("wait_result", result_bcd, 16'h0000);
        chk("wait_flags", {led_go, foul, timeout}, 3'b000);
    endtask

    task automatic wait_go(input int d);
        int n;
        n = 0;
        while (state != 3'd2 && n < 100) begin
            chk("wait_no_led", led_go, 1'b0);
            cyc(1);
            n++;
        end
        chk("go_latency", n, 4 * d);
        chk("go_led", led_go, 1'b1);
    endtask

    // mode 0: respond k cycles after GO; mode 1: foul k cycles into WAIT (k<0: random).
    task automatic trial(input int mode, input int k, input bit want_lfsr1);
        int d;
        int kk;
        begin_trial(want_lfsr1, d);
        if (mode == 1) begin
            kk = (k < 0) ? int'($urandom_range(4 * d - 1)) : k;
            cyc(kk);
            chk("foul_no_led", led_go, 1'b0);
            respond = 1'b1;
            cyc(1);
            respond = 1'b0;
            chk("foul_state", state, 3'd4);
            chk("foul_flag", foul, 1'b1);
            chk("foul_result", result_bcd, 16'h0000);
            chk("foul_led", led_go, 1'b0);
            cyc(1);
            chk("foul_best", best_bcd, exp_best);
            return;
        end
        kk = (k < 0) ? int'($urandom_range(60)) : k;
        wait_go(d);
        // A start press inside GO must not disturb the measurement.
        if (kk >= 2 && $urandom_range(1) == 1) begin
            start = 1'b1;
            cyc(1);
            start = 1'b0;
            cyc(kk - 1);
        end else begin
            cyc(kk);
        end
        respond = 1'b1;
        cyc(1);
        chk("done_state", state, 3'd3);
        chk("done_result", result_bcd, to_bcd(kk / TD));
        chk("done_led", led_go, 1'b0);
        chk("done_best_old", best_bcd, exp_best);
`ifdef BEST_TIME_EN
        if (to_bcd(kk / TD) < exp_best) exp_best = to_bcd(kk / TD);
`endif
        cyc(1);
        chk("done_best_new", best_bcd, exp_best);
        cyc(2);
        chk("done_hold", result_bcd, to_bcd(kk / TD));
        respond = 1'b0;
        cyc(1);
        respond = 1'b1;
        cyc(1);
        respond = 1'b0;
        chk("done_ignore_resp", {state, result_bcd}, {3'd3, to_bcd(kk / TD)});
    endtask

    initial begin
        int d;
        int n;

        // Reset with start held high; the held level must not count as a press.
        reset = 1'b1;
        start = 1'b1;
        cyc(3);
        chk("rst_state", state, 3'd0);
        chk("rst_flags", {led_go, foul, timeout}, 3'b000);
        chk("rst_result", result_bcd, 16'h0000);
        chk("rst_best", best_bcd, 16'h9999);
        reset = 1'b0;
        cyc(3);
        chk("rst_held_start", state, 3'd0);

        // Best-time sequence 5, 3, foul, 8; then the respond/tick coincidence.
        trial(0, 21, 1'b1);
        trial(0, 13, 1'b0);
        trial(1, 3, 1'b0);
        trial(0, 33, 1'b0);
        trial(0, 27, 1'b0);
        trial(1, -1, 1'b0);

        // Carry chain and timeout.
        begin_trial(1'b0, d);
        wait_go(d);
        n = 0;
        while (state == 3'd2 && n < 41000) begin
            cyc(1);
            n++;
            if (n % TD == 0 && (n / TD == 9 || n / TD == 10 || n / TD == 99 ||
                                n / TD == 100 || n / TD == 999 || n / TD == 1000))
                chk("carry", result_bcd, to_bcd(n / TD));
        end
        chk("to_latency", n, 4 * 10000);
        chk("to_state", state, 3'd5);
        chk("to_flags", {led_go, foul, timeout}, 3'b001);
        chk("to_result", result_bcd, 16'h9999);
        chk("to_best", best_bcd, exp_best);

        // Reset asserted in GO.
        begin_trial(1'b0, d);
        wait_go(d);
        cyc(6);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        exp_best = 16'h9999;
        chk("rst_go_state", state, 3'd0);
        chk("rst_go_led", led_go, 1'b0);
        chk("rst_go_result", result_bcd, 16'h0000);
        chk("rst_go_best", best_bcd, 16'h9999);

        // Random mix of trials.
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(3) == 0) trial(1, -1, 1'b0);
            else                        trial(0, -1, 1'b0);
            cyc(int'($urandom_range(5)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
